// File: rtl/adder_bk_pipe.sv
// Brent-Kung prefix adder/subtractor with ripple groups, 0..3 pipeline stages and
// valid/ready flow control. {co,sum} = a + (sub ? ~b : b) + (sub ? 1 : ci).
module adder_bk_pipe #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP;

    if (WIDTH < 2 || WIDTH > 64 || (WIDTH % GROUP) != 0 || STAGES < 0 || STAGES > 3 ||
        !(GROUP == 1 || GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_bad_param
        $error("adder_bk_pipe: illegal WIDTH/GROUP/STAGES combination");
    end

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             c0;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
    } tree_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
        logic             zero;
    } res_t;

    localparam res_t RES_RST = '{sum: '0, co: 1'b0, ovf: 1'b0, zero: 1'b1};

    // ---------------- flow control ----------------
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] rdy;

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES];

    if (STAGES == 0) begin : g_comb_vld
        assign vld_pipe = in_valid;
        assign rdy      = out_ready;
    end else begin : g_seq_vld
        logic [STAGES-1:0] vld_q;

        assign vld_pipe = {vld_q, in_valid};

        // rdy[k]: slot k+1 can take a beat this cycle (empty, or draining downstream)
        always_comb begin
            rdy         = '0;
            rdy[STAGES] = out_ready;
            for (int k = STAGES - 1; k >= 0; k--)
                rdy[k] = ~vld_q[k] | rdy[k+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                for (int k = 0; k < STAGES; k++)
                    if (rdy[k]) vld_q[k] <= vld_pipe[k];
            end
        end
    end

    // ---------------- datapath ----------------
    tree_t gp_c, gp_q, up_c, up_q;
    res_t  res_c, res_q;

    always_comb begin : grp_gp
        logic [WIDTH-1:0] bx;
        logic             gg_t, gp_t;
        bx      = sub ? ~b : b;
        gg_t    = 1'b0;
        gp_t    = 1'b1;
        gp_c    = '0;
        gp_c.g  = a & bx;
        gp_c.p  = a ^ bx;
        gp_c.c0 = sub | ci;
        for (int i = 0; i < NG; i++) begin
            gg_t = 1'b0;
            gp_t = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gg_t = gp_c.g[i*GROUP+j] | (gp_c.p[i*GROUP+j] & gg_t);
                gp_t = gp_t & gp_c.p[i*GROUP+j];
            end
            gp_c.gg[i] = gg_t;
            gp_c.gp[i] = gp_t;
        end
        // Carry-in folded into group 0 so every prefix G is the carry out of its group
        gp_c.gg[0] = gp_c.gg[0] | (gp_c.gp[0] & gp_c.c0);
    end

    always_comb begin : up_sweep
        up_c = gp_q;
        for (int d = 1; d < NG; d = d * 2) begin
            for (int i = 2 * d - 1; i < NG; i += 2 * d) begin
                up_c.gg[i] = up_c.gg[i] | (up_c.gp[i] & up_c.gg[i-d]);
                up_c.gp[i] = up_c.gp[i] & up_c.gp[i-d];
            end
        end
    end

    always_comb begin : down_sum
        logic [NG-1:0] cg, cp;
        logic          c, c_msb;
        cg = up_q.gg;
        cp = up_q.gp;
        for (int d = 64; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < NG; i += 2 * d) begin
                cg[i] = cg[i] | (cp[i] & cg[i-d]);
                cp[i] = cp[i] & cp[i-d];
            end
        end
        res_c = RES_RST;
        c     = up_q.c0;
        c_msb = 1'b0;
        for (int i = 0; i < NG; i++) begin
            for (int j = 0; j < GROUP; j++) begin
                c_msb = c;
                res_c.sum[i*GROUP+j] = up_q.p[i*GROUP+j] ^ c;
                c = up_q.g[i*GROUP+j] | (up_q.p[i*GROUP+j] & c);
            end
            // The next group starts from the tree carry, not the local ripple
            c = cg[i];
        end
        res_c.co   = c;
        res_c.ovf  = c_msb ^ c;
        res_c.zero = ~|res_c.sum;
    end

    // ---------------- stage registers ----------------
    if (STAGES >= 2) begin : g_reg_gp
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                       gp_q <= '0;
            else if (rdy[0] & vld_pipe[0]) gp_q <= gp_c;
        end
    end else begin : g_thru_gp
        assign gp_q = gp_c;
    end

    if (STAGES == 3) begin : g_reg_up
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                       up_q <= '0;
            else if (rdy[1] & vld_pipe[1]) up_q <= up_c;
        end
    end else begin : g_thru_up
        assign up_q = up_c;
    end

    if (STAGES >= 1) begin : g_reg_res
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                   res_q <= RES_RST;
            else if (rdy[STAGES-1] & vld_pipe[STAGES-1]) res_q <= res_c;
        end
    end else begin : g_thru_res
        assign res_q = res_c;
    end

    assign sum  = res_q.sum;
    assign co   = res_q.co;
    assign ovf  = res_q.ovf;
    assign zero = res_q.zero;

endmodule

// File: tb/tb_adder_bk_pipe.sv
// Bench for adder_bk_pipe: directed vector table, reset/back-pressure sequences,
// random-handshake streams on 16/4/2 and 12/4/3, and a sweep of the 8/1/0 combinational build.
module tb_adder_bk_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam int MS = 2;
    localparam int NB = 10000;

    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, sum;
    adder_bk_pipe #(.WIDTH(16), .GROUP(4), .STAGES(MS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .co(co), .ovf(ovf), .zero(zero));

    logic       c_in_valid, c_in_ready, c_ci, c_sub, c_out_valid, c_out_ready, c_co, c_ovf, c_zero;
    logic [7:0] c_a, c_b, c_sum;
    adder_bk_pipe #(.WIDTH(8), .GROUP(1), .STAGES(0)) u_comb (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .a(c_a), .b(c_b),
        .ci(c_ci), .sub(c_sub), .out_valid(c_out_valid), .out_ready(c_out_ready), .sum(c_sum),
        .co(c_co), .ovf(c_ovf), .zero(c_zero));

    logic        t_in_valid, t_in_ready, t_ci, t_sub, t_out_valid, t_out_ready, t_co, t_ovf, t_zero;
    logic [11:0] t_a, t_b, t_sum;
    adder_bk_pipe #(.WIDTH(12), .GROUP(4), .STAGES(3)) u_deep (
        .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .a(t_a), .b(t_b),
        .ci(t_ci), .sub(t_sub), .out_valid(t_out_valid), .out_ready(t_out_ready), .sum(t_sum),
        .co(t_co), .ovf(t_ovf), .zero(t_zero));

    int n_tests = 0;
    int n_fail  = 0;

    // Returns {co, ovf, zero, sum[15:0]} for a w-bit operation
    function automatic logic [18:0] ref_fn(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic cin, input logic s);
        logic [16:0] full;
        logic [15:0] m, yx, r;
        logic        c, v;
        m    = 16'hFFFF >> (16 - w);
        yx   = (s ? ~y : y) & m;
        full = {1'b0, x & m} + {1'b0, yx} + 17'(s | cin);
        r    = full[15:0] & m;
        c    = full[w];
        v    = (x[w-1] == yx[w-1]) && (r[w-1] != x[w-1]);
        return {c, v, (r == 16'h0), r};
    endfunction

    function automatic logic [18:0] m_out();
        return {co, ovf, zero, sum};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic cin, input logic s);
        a = x; b = y; ci = cin; sub = s;
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sub;
        logic [15:0] s;
        logic        co, ov, z;
    } vec_t;
    vec_t vt[10];

    logic [18:0] q_m[$];
    logic [18:0] q_t[$];
    logic [18:0] ea, eb, ec, r8;

    initial begin
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[9] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; drive(16'h0, 16'h0, 1'b0, 1'b0);
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_a = '0; c_b = '0; c_ci = 1'b0; c_sub = 1'b0;
        t_in_valid = 1'b0; t_out_ready = 1'b0; t_a = '0; t_b = '0; t_ci = 1'b0; t_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", m_out(), {3'b001, 16'h0000});
        check("rst_deep_out_valid", t_out_valid, 0);
        check("rst_deep_outputs", {t_co, t_ovf, t_zero, t_sum}, {3'b001, 12'h000});
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed table: one beat at a time, exact latency
        out_ready = 1'b1;
        foreach (vt[i]) begin
            @(posedge clk); #1;
            drive(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub);
            in_valid = 1'b1;
            @(negedge clk);
            check("vec_in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 1; k <= MS; k++) begin
                @(negedge clk);
                check($sformatf("vec%0d_latency%0d", i, k), out_valid, (k == MS));
                if (k < MS) @(posedge clk);
            end
            check($sformatf("vec%0d_result", i), m_out(), {vt[i].co, vt[i].ov, vt[i].z, vt[i].s});
        end

        // Reset with two beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(16'h3333, 16'h0001, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("inflight_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", m_out(), {3'b001, 16'h0000});
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_no_stale", out_valid, 0);
        end

        // Back-pressure: two beats absorbed, third refused, drain in order
        ea = ref_fn(16, 16'h0001, 16'h0002, 1'b0, 1'b0);
        eb = ref_fn(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        ec = ref_fn(16, 16'h8000, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; drive(16'h0001, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_accept_a", in_ready, 1);
        @(posedge clk); #1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_accept_b", in_ready, 1);
        @(posedge clk); #1;
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_full_in_ready", in_ready, 0);
            check("bp_held_valid", out_valid, 1);
            check("bp_held_a", m_out(), ea);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_emit_a", m_out(), ea);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_emit_b_valid", out_valid, 1);
        check("bp_emit_b", m_out(), eb);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_emit_c_valid", out_valid, 1);
        check("bp_emit_c", m_out(), ec);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Random streams with random back-pressure on both pipelined builds
        begin
            int sent_m, got_m, sent_t, got_t, cyc;
            sent_m = 0; got_m = 0; sent_t = 0; got_t = 0; cyc = 0;
            while ((got_m < NB || got_t < NB) && cyc < 60000) begin
                @(posedge clk); #1;
                cyc++;
                in_valid  = (sent_m < NB) && ($urandom_range(0, 3) != 0);
                drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                out_ready = (sent_m >= NB) || ($urandom_range(0, 1) == 1);
                t_in_valid  = (sent_t < NB) && ($urandom_range(0, 1) == 1);
                t_a = 12'($urandom); t_b = 12'($urandom); t_ci = 1'($urandom); t_sub = 1'($urandom);
                t_out_ready = (sent_t >= NB) || ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    q_m.push_back(ref_fn(16, a, b, ci, sub));
                    sent_m++;
                end
                if (out_valid && out_ready) begin
                    if (q_m.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL stream16_extra: got beat %h expected none", m_out());
                    end else begin
                        check("stream16", m_out(), q_m.pop_front());
                    end
                    got_m++;
                end
                if (t_in_valid && t_in_ready) begin
                    q_t.push_back(ref_fn(12, {4'h0, t_a}, {4'h0, t_b}, t_ci, t_sub));
                    sent_t++;
                end
                if (t_out_valid && t_out_ready) begin
                    if (q_t.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL stream12_extra: got beat %h expected none", t_sum);
                    end else begin
                        check("stream12", {t_co, t_ovf, t_zero, 4'h0, t_sum}, q_t.pop_front());
                    end
                    got_t++;
                end
            end
            in_valid = 1'b0; t_in_valid = 1'b0;
            check("stream16_count", got_m, NB);
            check("stream12_count", got_t, NB);
            check("stream16_left", q_m.size(), 0);
            check("stream12_left", q_t.size(), 0);
        end

        // Combinational build: every (a,b) pair, mode and handshake pass-through
        for (int i = 0; i < 65536; i++) begin
            c_a = i[7:0];
            c_b = i[15:8];
            c_ci  = i[0] ^ i[8];
            c_sub = i[1] ^ i[9];
            c_in_valid  = i[2];
            c_out_ready = i[10];
            #1;
            r8 = ref_fn(8, {8'h00, c_a}, {8'h00, c_b}, c_ci, c_sub);
            check("comb8", {c_out_valid, c_in_ready, c_co, c_ovf, c_zero, c_sum},
                  {c_in_valid, c_out_ready, r8[18:16], r8[7:0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
